// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select, access size, FSM states.
package wb_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wbState_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian lane extraction with sign/zero extension and misalignment detect.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LO_W   = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              isUnsigned,
  input  logic [LO_W-1:0]   addrLo,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [1:0]        effSize;
  logic [DATA_W-1:0] shifted;
  logic [LO_W-1:0]   alignMask;
  logic              fillBit;
  int                nBits;

  always_comb begin
    // A 32-bit datapath has no dword lane; such accesses behave as words.
    effSize = size;
    if (DATA_W == 32 && size == SZ_D) effSize = SZ_W;

    case (effSize)
      SZ_B:    alignMask = '0;
      SZ_H:    alignMask = LO_W'(1);
      SZ_W:    alignMask = LO_W'(3);
      default: alignMask = LO_W'(7);
    endcase
    misalign = |(addrLo & alignMask);

    shifted = rdata >> {addrLo, 3'b000};
    nBits   = 8 << effSize;
    fillBit = ~isUnsigned & shifted[nBits-1];
    data    = shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nBits) data[i] = fillBit;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Registered MEM/WB boundary: source select, load alignment and a wait state
// for variable-latency load data, driving the register-file write port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1,
  parameter int LO_W       = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] dest_reg_in,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [LO_W-1:0]       addr_lo,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     link_addr,
  input  logic [DATA_W-1:0]     imm,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] load_pending_reg,
  output logic                  misalign_err
);

  wbState_e state, stateNext;

  logic                  accept;
  logic                  rvalidLive;
  logic                  loadDone;
  logic                  loadFault;
  logic [DATA_W-1:0]     srcData;
  logic [DATA_W-1:0]     alignData;
  logic                  alignMisalign;

  logic                  regWrite_p1;
  logic [REG_ADDR_W-1:0] destReg_p1;
  logic [1:0]            memSize_p1;
  logic                  memUnsigned_p1;
  logic [LO_W-1:0]       addrLo_p1;

  function automatic logic destAllowed(input logic [REG_ADDR_W-1:0] dest);
    return !(ZERO_REG != 0 && dest == '0);
  endfunction

  assign in_ready         = (state != WAIT_MEM);
  assign accept           = in_valid & in_ready & ~flush;
  assign load_pending     = (state == WAIT_MEM);
  assign load_pending_reg = destReg_p1;

  // A flush in the wait state wins over data arriving in the same cycle.
  assign rvalidLive = (state == WAIT_MEM) & mem_rvalid & ~flush;
  assign loadDone   = rvalidLive & ~alignMisalign;
  assign loadFault  = rvalidLive & alignMisalign;

  always_comb begin
    case (wb_sel)
      WB_LINK: srcData = link_addr;
      WB_IMM:  srcData = imm;
      default: srcData = alu_result;
    endcase
  end

  load_align #(
    .DATA_W(DATA_W),
    .LO_W  (LO_W)
  ) u_align (
    .rdata     (mem_rdata),
    .size      (memSize_p1),
    .isUnsigned(memUnsigned_p1),
    .addrLo    (addrLo_p1),
    .data      (alignData),
    .misalign  (alignMisalign)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, WRITE: begin
        stateNext = IDLE;
        if (accept) stateNext = (wb_sel == WB_MEM) ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        if (flush)           stateNext = IDLE;
        else if (mem_rvalid) stateNext = alignMisalign ? IDLE : WRITE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Stage p1: control and write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      regWrite_p1  <= 1'b0;
      destReg_p1   <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= stateNext;
      rf_we        <= 1'b0;
      misalign_err <= loadFault;
      if (accept) begin
        regWrite_p1 <= reg_write_in;
        destReg_p1  <= dest_reg_in;
        if (wb_sel != WB_MEM && reg_write_in && destAllowed(dest_reg_in)) begin
          rf_we    <= 1'b1;
          rf_waddr <= dest_reg_in;
          rf_wdata <= srcData;
        end
      end
      if (loadDone && regWrite_p1 && destAllowed(destReg_p1)) begin
        rf_we    <= 1'b1;
        rf_waddr <= destReg_p1;
        rf_wdata <= alignData;
      end
    end
  end

  // Stage p1: load attributes, only meaningful while a load is held
  always_ff @(posedge clk) begin
    if (accept) begin
      memSize_p1     <= mem_size;
      memUnsigned_p1 <= mem_unsigned;
      addrLo_p1      <= addr_lo;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: three instances (32-bit, 32-bit without r0 suppression,
// 64-bit) share one stimulus stream, each tracked by a transaction-level model.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inValid, flush, regWrite, memUnsigned, memRvalid;
  logic [4:0]  destReg;
  logic [1:0]  wbSel, memSize;
  logic [2:0]  addrLo;
  logic [63:0] aluResult, linkAddr, immVal, memRdata;

  logic        rdyA, weA, lpA, misA, rdyB, weB, lpB, misB, rdyC, weC, lpC, misC;
  logic [4:0]  waA, lprA, waB, lprB, waC, lprC;
  logic [31:0] wdA, wdB;
  logic [63:0] wdC;

  wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG(1)) dutA (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyA), .flush(flush),
    .reg_write_in(regWrite), .dest_reg_in(destReg), .wb_sel(wbSel), .mem_size(memSize),
    .mem_unsigned(memUnsigned), .addr_lo(addrLo[1:0]), .alu_result(aluResult[31:0]),
    .link_addr(linkAddr[31:0]), .imm(immVal[31:0]), .mem_rdata(memRdata[31:0]),
    .mem_rvalid(memRvalid), .rf_we(weA), .rf_waddr(waA), .rf_wdata(wdA),
    .load_pending(lpA), .load_pending_reg(lprA), .misalign_err(misA));

  wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyB), .flush(flush),
    .reg_write_in(regWrite), .dest_reg_in(destReg), .wb_sel(wbSel), .mem_size(memSize),
    .mem_unsigned(memUnsigned), .addr_lo(addrLo[1:0]), .alu_result(aluResult[31:0]),
    .link_addr(linkAddr[31:0]), .imm(immVal[31:0]), .mem_rdata(memRdata[31:0]),
    .mem_rvalid(memRvalid), .rf_we(weB), .rf_waddr(waB), .rf_wdata(wdB),
    .load_pending(lpB), .load_pending_reg(lprB), .misalign_err(misB));

  wb_stage #(.DATA_W(64), .REG_ADDR_W(5), .ZERO_REG(1)) dutC (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(rdyC), .flush(flush),
    .reg_write_in(regWrite), .dest_reg_in(destReg), .wb_sel(wbSel), .mem_size(memSize),
    .mem_unsigned(memUnsigned), .addr_lo(addrLo), .alu_result(aluResult),
    .link_addr(linkAddr), .imm(immVal), .mem_rdata(memRdata),
    .mem_rvalid(memRvalid), .rf_we(weC), .rf_waddr(waC), .rf_wdata(wdC),
    .load_pending(lpC), .load_pending_reg(lprC), .misalign_err(misC));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: a held load (if any) plus the last committed write.
  typedef struct {
    bit          pend;
    bit          rw;
    logic [4:0]  dest;
    logic [1:0]  sz;
    bit          uns;
    logic [2:0]  lo;
    bit          we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    bit          mis;
    logic [4:0]  lpReg;
  } model_t;

  model_t mA, mB, mC, mZero;

  function automatic int bytesOf(input int dataW, input logic [1:0] sz);
    if (sz == 2'd3 && dataW == 32) return 4;
    return 1 << sz;
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] word, input int dataW,
                                          input logic [1:0] sz, input bit uns, input logic [2:0] lo);
    int          nb;
    logic [63:0] v, keep;
    nb   = bytesOf(dataW, sz);
    v    = word >> (8 * int'(lo));
    keep = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & keep;
    if (!uns && v[8*nb-1]) v = v | ~keep;
    if (dataW == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic model_t modelStep(input model_t m, input int dataW, input bit zeroReg);
    model_t      n;
    logic [63:0] msk;
    n     = m;
    n.we  = 1'b0;
    n.mis = 1'b0;
    msk   = (dataW == 64) ? '1 : 64'hFFFF_FFFF;
    if (m.pend) begin
      if (flush) n.pend = 1'b0;
      else if (memRvalid) begin
        n.pend = 1'b0;
        if ((int'(m.lo) % bytesOf(dataW, m.sz)) != 0) n.mis = 1'b1;
        else if (m.rw && !(zeroReg && m.dest == 5'd0)) begin
          n.we    = 1'b1;
          n.waddr = m.dest;
          n.wdata = extract(memRdata & msk, dataW, m.sz, m.uns, m.lo);
        end
      end
    end else if (inValid && !flush) begin
      n.lpReg = destReg;
      if (wbSel == WB_MEM) begin
        n.pend = 1'b1;
        n.rw   = regWrite;
        n.dest = destReg;
        n.sz   = memSize;
        n.uns  = memUnsigned;
        n.lo   = (dataW == 64) ? addrLo : {1'b0, addrLo[1:0]};
      end else if (regWrite && !(zeroReg && destReg == 5'd0)) begin
        n.we    = 1'b1;
        n.waddr = destReg;
        n.wdata = ((wbSel == WB_LINK) ? linkAddr : (wbSel == WB_IMM) ? immVal : aluResult) & msk;
      end
    end
    return n;
  endfunction

  task automatic checkDut(input string tag, input model_t m, input logic rdy, input logic we,
                          input logic lp, input logic mis, input logic [4:0] wa,
                          input logic [4:0] lpr, input logic [63:0] wd);
    chk({tag, ".in_ready"}, 64'(rdy), 64'(!m.pend));
    chk({tag, ".rf_we"}, 64'(we), 64'(m.we));
    chk({tag, ".rf_waddr"}, 64'(wa), 64'(m.waddr));
    chk({tag, ".rf_wdata"}, wd, m.wdata);
    chk({tag, ".load_pending"}, 64'(lp), 64'(m.pend));
    chk({tag, ".load_pending_reg"}, 64'(lpr), 64'(m.lpReg));
    chk({tag, ".misalign_err"}, 64'(mis), 64'(m.mis));
  endtask

  task automatic compareAll();
    checkDut("A", mA, rdyA, weA, lpA, misA, waA, lprA, {32'd0, wdA});
    checkDut("B", mB, rdyB, weB, lpB, misB, waB, lprB, {32'd0, wdB});
    checkDut("C", mC, rdyC, weC, lpC, misC, waC, lprC, wdC);
  endtask

  task automatic tick();
    mA = modelStep(mA, 32, 1'b1);
    mB = modelStep(mB, 32, 1'b0);
    mC = modelStep(mC, 64, 1'b1);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic setInstr(input logic [4:0] d, input logic [1:0] sel, input logic [1:0] sz,
                          input logic uns, input logic [2:0] lo);
    inValid     = 1'b1;
    regWrite    = 1'b1;
    destReg     = d;
    wbSel       = sel;
    memSize     = sz;
    memUnsigned = uns;
    addrLo      = lo;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] alu, link, imm;
    logic        expWeA;
    logic [4:0]  expAddrA;
    logic [31:0] expDataA;
    logic        expWeB;
    logic [4:0]  expAddrB;
    logic [31:0] expDataB;
  } vec_t;

  vec_t vecs[8];

  initial begin
    mZero = '{default: '0};
    mA = mZero; mB = mZero; mC = mZero;
    inValid = 1'b0; flush = 1'b0; regWrite = 1'b0; memUnsigned = 1'b0; memRvalid = 1'b0;
    destReg = '0; wbSel = '0; memSize = '0; addrLo = '0;
    aluResult = '0; linkAddr = '0; immVal = '0; memRdata = '0;

    //           sel      rw    dest   alu            link          imm         weA   addrA  dataA          weB   addrB  dataB
    vecs[0] = '{WB_ALU,  1'b1, 5'd5,  32'd1,         32'd0,        32'd0,      1'b1, 5'd5,  32'd1,         1'b1, 5'd5,  32'd1};
    vecs[1] = '{WB_ALU,  1'b1, 5'd6,  32'd2,         32'd0,        32'd0,      1'b1, 5'd6,  32'd2,         1'b1, 5'd6,  32'd2};
    vecs[2] = '{WB_ALU,  1'b1, 5'd7,  32'd3,         32'd0,        32'd0,      1'b1, 5'd7,  32'd3,         1'b1, 5'd7,  32'd3};
    vecs[3] = '{WB_ALU,  1'b1, 5'd8,  32'd4,         32'd0,        32'd0,      1'b1, 5'd8,  32'd4,         1'b1, 5'd8,  32'd4};
    vecs[4] = '{WB_LINK, 1'b1, 5'd9,  32'h11,        32'h1000,     32'h22,     1'b1, 5'd9,  32'h1000,      1'b1, 5'd9,  32'h1000};
    vecs[5] = '{WB_IMM,  1'b1, 5'd10, 32'h33,        32'h44,       32'hABCD,   1'b1, 5'd10, 32'hABCD,      1'b1, 5'd10, 32'hABCD};
    vecs[6] = '{WB_ALU,  1'b1, 5'd0,  32'hDEAD_BEEF, 32'd0,        32'd0,      1'b0, 5'd10, 32'hABCD,      1'b1, 5'd0,  32'hDEAD_BEEF};
    vecs[7] = '{WB_ALU,  1'b0, 5'd11, 32'h55,        32'd0,        32'd0,      1'b0, 5'd10, 32'hABCD,      1'b0, 5'd0,  32'hDEAD_BEEF};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back non-load stream, table driven
    for (int i = 0; i < 8; i++) begin
      setInstr(vecs[i].dest, vecs[i].sel, SZ_W, 1'b0, 3'd0);
      regWrite  = vecs[i].rw;
      aluResult = {32'd0, vecs[i].alu};
      linkAddr  = {32'd0, vecs[i].link};
      immVal    = {32'd0, vecs[i].imm};
      tick();
      chk($sformatf("vec%0d.weA", i), 64'(weA), 64'(vecs[i].expWeA));
      chk($sformatf("vec%0d.waddrA", i), 64'(waA), 64'(vecs[i].expAddrA));
      chk($sformatf("vec%0d.wdataA", i), 64'(wdA), 64'(vecs[i].expDataA));
      chk($sformatf("vec%0d.weB", i), 64'(weB), 64'(vecs[i].expWeB));
      chk($sformatf("vec%0d.waddrB", i), 64'(waB), 64'(vecs[i].expAddrB));
      chk($sformatf("vec%0d.wdataB", i), 64'(wdB), 64'(vecs[i].expDataB));
      chk($sformatf("vec%0d.readyA", i), 64'(rdyA), 64'd1);
    end
    inValid = 1'b0;
    tick();

    // Signed then unsigned byte load at lane 2, data three cycles after accept
    for (int u = 0; u < 2; u++) begin
      setInstr(5'd12, WB_MEM, SZ_B, 1'(u), 3'd2);
      memRdata = 64'h0000_0000_1280_3456;
      tick();
      inValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ld%0d.pending%0d", u, k), 64'(lpA), 64'd1);
        memRvalid = (k == 2);
        if (k < 2) tick();
      end
      tick();
      memRvalid = 1'b0;
      chk($sformatf("ld%0d.we", u), 64'(weA), 64'd1);
      chk($sformatf("ld%0d.wdata", u), 64'(wdA), (u == 0) ? 64'hFFFF_FF80 : 64'h0000_0080);
      chk($sformatf("ld%0d.wdata64", u), wdC, (u == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
      tick();
    end

    // Misaligned half load
    setInstr(5'd13, WB_MEM, SZ_H, 1'b0, 3'd1);
    tick();
    inValid   = 1'b0;
    memRvalid = 1'b1;
    tick();
    memRvalid = 1'b0;
    chk("misalign.pulse", 64'(misA), 64'd1);
    chk("misalign.nowe", 64'(weA), 64'd0);
    tick();
    chk("misalign.cleared", 64'(misA), 64'd0);

    // Flush in the wait state with data arriving the same cycle
    setInstr(5'd14, WB_MEM, SZ_W, 1'b0, 3'd0);
    tick();
    inValid   = 1'b0;
    flush     = 1'b1;
    memRvalid = 1'b1;
    tick();
    flush     = 1'b0;
    memRvalid = 1'b0;
    chk("flush.nowe", 64'(weA), 64'd0);
    chk("flush.ready", 64'(rdyA), 64'd1);
    chk("flush.pending", 64'(lpA), 64'd0);
    tick();
    chk("flush.stillnowe", 64'(weA), 64'd0);

    // Dword then upper-lane signed word on the 64-bit datapath
    setInstr(5'd15, WB_MEM, SZ_D, 1'b0, 3'd0);
    memRdata = 64'hF0E1_D2C3_B4A5_9687;
    tick();
    inValid   = 1'b0;
    memRvalid = 1'b1;
    tick();
    memRvalid = 1'b0;
    chk("dword.wdata64", wdC, 64'hF0E1_D2C3_B4A5_9687);
    chk("dword.wdata32", 64'(wdA), 64'hB4A5_9687);
    setInstr(5'd16, WB_MEM, SZ_W, 1'b0, 3'd4);
    memRdata = 64'h8000_0001_1234_5678;
    tick();
    inValid   = 1'b0;
    memRvalid = 1'b1;
    tick();
    memRvalid = 1'b0;
    chk("upperword.wdata64", wdC, 64'hFFFF_FFFF_8000_0001);
    chk("upperword.we64", 64'(weC), 64'd1);
    tick();

    // Asynchronous reset while a load is held
    setInstr(5'd20, WB_MEM, SZ_W, 1'b0, 3'd0);
    aluResult = 64'h1234;
    tick();
    inValid = 1'b0;
    chk("rstload.pending", 64'(lpC), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    mA = mZero; mB = mZero; mC = mZero;
    compareAll();
    @(negedge clk);
    rst       = 1'b0;
    memRvalid = 1'b1;
    tick();
    tick();
    memRvalid = 1'b0;
    chk("rstload.nowrite", 64'(weA), 64'd0);

    // Randomised traffic against the models
    for (int c = 0; c < 600; c++) begin
      inValid     = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 11) == 0);
      regWrite    = ($urandom_range(0, 4) != 0);
      destReg     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      wbSel       = 2'($urandom);
      memSize     = 2'($urandom);
      memUnsigned = 1'($urandom);
      addrLo      = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      memRvalid   = ($urandom_range(0, 2) == 0);
      aluResult   = {$urandom, $urandom};
      linkAddr    = {$urandom, $urandom};
      immVal      = {$urandom, $urandom};
      memRdata    = {$urandom, $urandom};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
